// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared constants and stream state encoding for the CNN front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int MNIST_WIDTH     = 28;
    localparam int MNIST_HEIGHT    = 28;
    localparam int PIXEL_BITS      = 8;
    localparam int FILTER_SIZE     = 5;
    localparam int FRAME_PIXELS    = MNIST_WIDTH * MNIST_HEIGHT;
    localparam int FRAME_ADDR_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_ram
// Description : Simple dual-port synchronous RAM, 1-cycle read, write-first.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_ram #(
    parameter int DEPTH     = 784,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic                 w_wr_ok;
    logic                 w_rd_ok;

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign w_rd_ok = {1'b0, rd_addr} < DEPTH_W;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
        // A same-address write in the read cycle is forwarded (write-first).
        if (rd_en) begin
            if (w_wr_ok && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else if (w_rd_ok) begin
                rd_data <= r_mem[rd_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/image_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : image_stream_tx
// Description : Streams a stored frame in raster order over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module image_stream_tx
    import cnn_pkg::*;
#(
    parameter int WIDTH     = MNIST_WIDTH,
    parameter int HEIGHT    = MNIST_HEIGHT,
    parameter int DATA_BITS = PIXEL_BITS,
    parameter int ADDR_BITS = FRAME_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ignored,
    input  logic                 start,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 last_out,
    output logic                 frame_done
);

    localparam int                   FRAME     = WIDTH * HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME - 1);

    stream_state_t        r_state;
    logic [ADDR_BITS-1:0] r_rd_addr;
    logic                 r_inflight;
    logic                 r_inflight_last;
    logic [DATA_BITS-1:0] r_skid_data;
    logic                 r_skid_last;
    logic                 r_skid_valid;
    logic [DATA_BITS-1:0] w_ram_q;
    logic [1:0]           w_fifo_count;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_ram_we;

    assign w_fifo_count = {1'b0, valid_out} + {1'b0, r_skid_valid};
    assign w_pop        = valid_out && ready_in;
    // Credit counts this cycle's pop so a full-rate stream keeps one read in flight.
    assign w_issue      = (r_state == ST_RUN) &&
                          ((w_fifo_count - {1'b0, w_pop} + {1'b0, r_inflight}) < 2'd2);
    assign w_ram_we     = wr_en && (r_state == ST_IDLE);

    frame_ram #(
        .DEPTH     (FRAME),
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (w_ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_issue),
        .rd_addr (r_rd_addr),
        .rd_data (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            wr_ignored      <= 1'b0;
        end else begin
            frame_done      <= 1'b0;
            wr_ignored      <= wr_en && (r_state != ST_IDLE);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == LAST_ADDR);
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_rd_addr <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_issue && (r_rd_addr == LAST_ADDR)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && last_out) begin
                        r_state    <= ST_DONE;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry skid FIFO: output register plus one overflow slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= '0;
            valid_out    <= 1'b0;
            last_out     <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!valid_out || w_pop) begin
            if (r_skid_valid) begin
                data_out     <= r_skid_data;
                last_out     <= r_skid_last;
                valid_out    <= 1'b1;
                r_skid_valid <= r_inflight;
                r_skid_data  <= w_ram_q;
                r_skid_last  <= r_inflight_last;
            end else begin
                valid_out <= r_inflight;
                last_out  <= r_inflight && r_inflight_last;
                if (r_inflight) begin
                    data_out <= w_ram_q;
                end
            end
        end else if (r_inflight) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_ram_q;
            r_skid_last  <= r_inflight_last;
        end
    end

endmodule
`default_nettype wire
